// File: rtl/elevator_fsm.sv
// elevator_fsm: two-floor elevator sequencer with latched calls, tick-timed travel and door intervals
module elevator_fsm #(
  parameter int MOVE_TIME = 5,
  parameter int DOOR_TIME = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       call_floor1,
  input  logic       call_floor2,
  output logic [2:0] state,
  output logic [2:0] counting_value,
  output logic       door_open,
  output logic [1:0] req_pending
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLOOR1 = 3'd1,
    FLOOR2 = 3'd2,
    GOING1 = 3'd3,
    GOING2 = 3'd4
  } state_t;
  localparam logic [2:0] MT = 3'(MOVE_TIME);
  localparam logic [3:0] DT = 4'(DOOR_TIME);
  state_t     st;
  logic [3:0] door_cnt;
  logic       up, here_call, other_call;
  logic [1:0] here_bit, other_bit, latch;
  // "here" is the floor the car is at or heading to; "other" is the opposite floor
  assign up         = (st == FLOOR2) || (st == GOING2);
  assign here_call  = up ? call_floor2 : call_floor1;
  assign other_call = up ? call_floor1 : call_floor2;
  assign other_bit  = up ? 2'b01 : 2'b10;
  assign here_bit   = ~other_bit;
  assign latch      = other_call ? other_bit : 2'b00;
  assign state      = st;
  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= IDLE;
      counting_value <= '0;
      door_open      <= 1'b0;
      req_pending    <= '0;
      door_cnt       <= '0;
    end else begin
      case (st)
        IDLE: begin
          st             <= FLOOR1;
          counting_value <= '0;
          door_open      <= 1'b0;
          door_cnt       <= '0;
          req_pending    <= req_pending | {call_floor2, call_floor1};
        end
        FLOOR1, FLOOR2: begin
          req_pending <= req_pending | latch;
          if (here_call) begin
            door_cnt  <= DT;
            door_open <= 1'b1;
          end else if (door_cnt == 4'd0 && |(req_pending & other_bit)) begin
            st             <= up ? GOING1 : GOING2;
            counting_value <= MT;
            door_open      <= 1'b0;
          end else if (tick && door_cnt != 4'd0) begin
            door_cnt  <= door_cnt - 4'd1;
            door_open <= door_cnt != 4'd1;
          end
        end
        GOING1, GOING2: begin
          // destination calls are dropped; only origin-floor calls latch
          if (counting_value == 3'd0) begin
            st          <= up ? FLOOR2 : FLOOR1;
            door_cnt    <= DT;
            door_open   <= 1'b1;
            req_pending <= (req_pending | latch) & ~here_bit;
          end else begin
            req_pending <= req_pending | latch;
            if (tick) counting_value <= counting_value - 3'd1;
          end
        end
        default: begin
          st             <= IDLE;
          counting_value <= '0;
          door_open      <= 1'b0;
          req_pending    <= '0;
          door_cnt       <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_elevator_fsm.sv
// tb_elevator_fsm: table-driven directed vectors plus bounded multi-cycle sequences
module tb_elevator_fsm;
  logic       clk = 1'b0;
  logic       rst, tick, call_floor1, call_floor2;
  logic [2:0] state, counting_value;
  logic       door_open;
  logic [1:0] req_pending;
  int         total = 0, passed = 0;

  typedef struct packed {
    logic [3:0] in;
    logic [2:0] s;
    logic [2:0] cv;
    logic       d;
    logic [1:0] q;
  } vec_t;
  vec_t vq[$];

  elevator_fsm #(.MOVE_TIME(5), .DOOR_TIME(3)) dut (
    .clk(clk), .rst(rst), .tick(tick), .call_floor1(call_floor1), .call_floor2(call_floor2),
    .state(state), .counting_value(counting_value), .door_open(door_open), .req_pending(req_pending)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [3:0] in, input logic [2:0] s, input logic [2:0] cv,
                     input logic d, input logic [1:0] q);
    vq.push_back('{in, s, cv, d, q});
  endtask

  task automatic check(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
  endtask

  task automatic step(input logic [3:0] in);
    {rst, tick, call_floor1, call_floor2} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int idx, input logic [2:0] s, input logic [2:0] cv,
                           input logic d, input logic [1:0] q);
    check("state", idx, state, s);
    check("counting_value", idx, counting_value, cv);
    check("door_open", idx, {2'b00, door_open}, {2'b00, d});
    check("req_pending", idx, {1'b0, req_pending}, {1'b0, q});
  endtask

  initial begin
    // in = {rst, tick, call_floor1, call_floor2}; expectations are post-edge values
    add(4'b1000, 3'd0, 3'd0, 1'b0, 2'b00);
    add(4'b1000, 3'd0, 3'd0, 1'b0, 2'b00);
    add(4'b0000, 3'd1, 3'd0, 1'b0, 2'b00);
    add(4'b0100, 3'd1, 3'd0, 1'b0, 2'b00);
    add(4'b0001, 3'd1, 3'd0, 1'b0, 2'b10);
    add(4'b0000, 3'd4, 3'd5, 1'b0, 2'b10);
    add(4'b0100, 3'd4, 3'd4, 1'b0, 2'b10);
    add(4'b0000, 3'd4, 3'd4, 1'b0, 2'b10);
    add(4'b0100, 3'd4, 3'd3, 1'b0, 2'b10);
    add(4'b0110, 3'd4, 3'd2, 1'b0, 2'b11);
    add(4'b0101, 3'd4, 3'd1, 1'b0, 2'b11);
    add(4'b0100, 3'd4, 3'd0, 1'b0, 2'b11);
    add(4'b0000, 3'd2, 3'd0, 1'b1, 2'b01);
    add(4'b0100, 3'd2, 3'd0, 1'b1, 2'b01);
    add(4'b0100, 3'd2, 3'd0, 1'b1, 2'b01);
    add(4'b0001, 3'd2, 3'd0, 1'b1, 2'b01);
    add(4'b0100, 3'd2, 3'd0, 1'b1, 2'b01);
    add(4'b0100, 3'd2, 3'd0, 1'b1, 2'b01);
    add(4'b0100, 3'd2, 3'd0, 1'b0, 2'b01);
    add(4'b0000, 3'd3, 3'd5, 1'b0, 2'b01);
    add(4'b0100, 3'd3, 3'd4, 1'b0, 2'b01);
    add(4'b1000, 3'd0, 3'd0, 1'b0, 2'b00);
    add(4'b0000, 3'd1, 3'd0, 1'b0, 2'b00);
    add(4'b0001, 3'd1, 3'd0, 1'b0, 2'b10);
    add(4'b0010, 3'd1, 3'd0, 1'b1, 2'b10);
    add(4'b0100, 3'd1, 3'd0, 1'b1, 2'b10);
    add(4'b0000, 3'd1, 3'd0, 1'b1, 2'b10);
    add(4'b0100, 3'd1, 3'd0, 1'b1, 2'b10);
    add(4'b0100, 3'd1, 3'd0, 1'b0, 2'b10);
    add(4'b0000, 3'd4, 3'd5, 1'b0, 2'b10);

    {rst, tick, call_floor1, call_floor2} = 4'b1000;
    @(negedge clk);
    foreach (vq[i]) begin
      step(vq[i].in);
      check_all(i, vq[i].s, vq[i].cv, vq[i].d, vq[i].q);
    end

    // travel to floor 2 with a steady tick, bounded
    begin
      int n = 0;
      while (state != 3'd2 && n < 20) begin
        step(4'b0100);
        n++;
      end
      check("arrive_floor2_cycles", 100, (n == 6) ? 3'd1 : 3'd0, 3'd1);
      check_all(101, 3'd2, 3'd0, 1'b1, 2'b00);
    end

    // no requests: door closes after the interval and the car stays parked
    for (int k = 0; k < 3; k++) step(4'b0100);
    check_all(102, 3'd2, 3'd0, 1'b0, 2'b00);
    for (int k = 0; k < 6; k++) step(4'b0100);
    check_all(103, 3'd2, 3'd0, 1'b0, 2'b00);

    // calling the current floor with the door closed reopens it without latching
    step(4'b0001);
    check_all(104, 3'd2, 3'd0, 1'b1, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
